chipalooza_project_sel: RTL and testbench



---
 rtl/chipalooza_project_sel.sv | 206 ++++++++++++++++++++
 tb/tb_chipalooza_project_sel.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/chipalooza_project_sel.sv
// Wishbone-controlled selector that hands the shared GPIOs to one sub-project.
// Every switch-over breaks the old project, waits a dead time, then makes the new one.
module chipalooza_project_sel #(
  parameter int          N_PROJ      = 8,
  parameter int          N_IO        = 27,
  parameter int          DEAD_CYCLES = 16,
  parameter logic [31:0] BASE_ADDR   = 32'h3000_0000
) (
  input  logic                     wb_clk_i,
  input  logic                     wb_rstn_i,
  input  logic                     wbs_stb_i,
  input  logic                     wbs_cyc_i,
  input  logic                     wbs_we_i,
  input  logic [3:0]               wbs_sel_i,
  input  logic [31:0]              wbs_adr_i,
  input  logic [31:0]              wbs_dat_i,
  output logic                     wbs_ack_o,
  output logic [31:0]              wbs_dat_o,
  input  logic [N_PROJ*N_IO-1:0]   proj_io_out,
  input  logic [N_PROJ*N_IO-1:0]   proj_io_oeb,
  output logic [N_IO-1:0]          io_out,
  output logic [N_IO-1:0]          io_oeb,
  output logic [N_PROJ-1:0]        proj_ena,
  output logic                     irq
);

  localparam logic [8:0] N_PROJ_W = 9'(N_PROJ);
  localparam logic [7:0] IDX_NONE = 8'hFF;

  typedef enum logic [1:0] {
    ST_STABLE,
    ST_BREAK,
    ST_DEAD,
    ST_MAKE
  } state_t;

  state_t            state_q, state_d;
  logic [7:0]        sel_q, sel_d;
  logic [15:0]       dead_q, dead_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic [1:0]        irqen_q, irqen_d;
  logic [7:0]        active_q, active_d;
  logic [7:0]        target_q, target_d;
  logic [15:0]       cnt_q, cnt_d;
  logic [N_PROJ-1:0] ena_q, ena_d;
  logic              irq_q, irq_d;
  logic              ack_q, ack_d;
  logic [31:0]       dat_q, dat_d;

  logic              wb_hit;
  logic              wb_req;
  logic              wr_sel, wr_dead, wr_status, wr_irqen;
  logic              rd_req;
  logic              busy;
  logic              sel_launch;
  logic              sel_reject;
  logic              done_set;
  logic              target_valid;
  logic [N_PROJ-1:0] target_onehot;
  logic [31:0]       rdata;
  logic              unused_bits;

  assign unused_bits = ^{wbs_adr_i[1:0], wbs_dat_i[31:16], wbs_sel_i[3:2]};

  assign wb_hit    = (wbs_adr_i[31:4] == BASE_ADDR[31:4]);
  assign wb_req    = wbs_stb_i & wbs_cyc_i & wb_hit & ~ack_q;
  assign rd_req    = wb_req & ~wbs_we_i;
  assign wr_sel    = wb_req & wbs_we_i & (wbs_adr_i[3:2] == 2'd0);
  assign wr_dead   = wb_req & wbs_we_i & (wbs_adr_i[3:2] == 2'd1);
  assign wr_status = wb_req & wbs_we_i & (wbs_adr_i[3:2] == 2'd2);
  assign wr_irqen  = wb_req & wbs_we_i & (wbs_adr_i[3:2] == 2'd3);

  assign busy       = (state_q != ST_STABLE);
  assign sel_launch = wr_sel & ~busy & wbs_sel_i[0];
  assign sel_reject = wr_sel & busy;

  // Out-of-range targets decode to no enable at all.
  assign target_valid = ({1'b0, target_q} < N_PROJ_W);

  for (genvar gi = 0; gi < N_PROJ; gi++) begin : g_onehot
    assign target_onehot[gi] = (target_q == 8'(gi));
  end

  always_comb begin
    rdata = 32'd0;
    case (wbs_adr_i[3:2])
      2'd0: rdata = {24'd0, sel_q};
      2'd1: rdata = {16'd0, dead_q};
      2'd2: rdata = {16'd0, active_q, 5'd0, err_q, done_q, busy};
      default: rdata = {30'd0, irqen_q};
    endcase
  end

  always_comb begin
    sel_d   = sel_q;
    dead_d  = dead_q;
    irqen_d = irqen_q;
    if (sel_launch) begin
      sel_d = wbs_dat_i[7:0];
    end
    if (wr_dead) begin
      if (wbs_sel_i[0]) dead_d[7:0]  = wbs_dat_i[7:0];
      if (wbs_sel_i[1]) dead_d[15:8] = wbs_dat_i[15:8];
    end
    if (wr_irqen && wbs_sel_i[0]) begin
      irqen_d = wbs_dat_i[1:0];
    end
  end

  always_comb begin
    state_d  = state_q;
    target_d = target_q;
    cnt_d    = cnt_q;
    active_d = active_q;
    ena_d    = ena_q;
    done_set = 1'b0;
    case (state_q)
      ST_STABLE: begin
        if (sel_launch) begin
          state_d  = ST_BREAK;
          target_d = wbs_dat_i[7:0];
          cnt_d    = (dead_q == 16'd0) ? 16'd1 : dead_q;
          ena_d    = '0;
        end
      end
      ST_BREAK: begin
        state_d = ST_DEAD;
      end
      ST_DEAD: begin
        if (cnt_q <= 16'd1) begin
          state_d  = ST_MAKE;
          ena_d    = target_onehot;
          active_d = target_valid ? target_q : IDX_NONE;
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      default: begin
        state_d  = ST_STABLE;
        done_set = 1'b1;
      end
    endcase
  end

  // Sticky flags: a hardware set on the same edge beats the W1C clear.
  always_comb begin
    done_d = (done_q & ~(wr_status & wbs_sel_i[0] & wbs_dat_i[1])) | done_set;
    err_d  = (err_q  & ~(wr_status & wbs_sel_i[0] & wbs_dat_i[2])) | sel_reject;
    irq_d  = (done_q & irqen_q[0]) | (err_q & irqen_q[1]);
    ack_d  = wb_req;
    dat_d  = rd_req ? rdata : 32'd0;
  end

  always_ff @(posedge wb_clk_i) begin
    if (!wb_rstn_i) begin
      state_q  <= ST_STABLE;
      sel_q    <= IDX_NONE;
      dead_q   <= 16'(DEAD_CYCLES);
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      irqen_q  <= 2'd0;
      active_q <= IDX_NONE;
      target_q <= IDX_NONE;
      cnt_q    <= 16'd0;
      ena_q    <= '0;
      irq_q    <= 1'b0;
      ack_q    <= 1'b0;
      dat_q    <= 32'd0;
    end else begin
      state_q  <= state_d;
      sel_q    <= sel_d;
      dead_q   <= dead_d;
      done_q   <= done_d;
      err_q    <= err_d;
      irqen_q  <= irqen_d;
      active_q <= active_d;
      target_q <= target_d;
      cnt_q    <= cnt_d;
      ena_q    <= ena_d;
      irq_q    <= irq_d;
      ack_q    <= ack_d;
      dat_q    <= dat_d;
    end
  end

  // GPIOs follow the active project only once the switch-over has settled.
  always_comb begin
    io_out = '0;
    io_oeb = '1;
    if (state_q == ST_STABLE) begin
      for (int k = 0; k < N_PROJ; k++) begin
        if (active_q == 8'(k)) begin
          io_out = proj_io_out[k*N_IO +: N_IO];
          io_oeb = proj_io_oeb[k*N_IO +: N_IO];
        end
      end
    end
  end

  assign proj_ena  = ena_q;
  assign irq       = irq_q;
  assign wbs_ack_o = ack_q;
  assign wbs_dat_o = dat_q;

endmodule

// File: tb/tb_chipalooza_project_sel.sv
// Directed bench for chipalooza_project_sel: bus responses go through a
// scoreboard queue, GPIO/enable/irq timing is checked cycle by cycle.
module tb_chipalooza_project_sel;
  localparam int N_PROJ = 8;
  localparam int N_IO   = 27;
  localparam logic [31:0] BASE = 32'h3000_0000;

  logic                   clk = 1'b0;
  logic                   rstn = 1'b0;
  logic                   stb = 1'b0, cyc = 1'b0, we = 1'b0;
  logic [3:0]             sel = 4'h0;
  logic [31:0]            adr = 32'd0, wdat = 32'd0;
  logic                   ack;
  logic [31:0]            rdat;
  logic [N_PROJ*N_IO-1:0] p_out, p_oeb;
  logic [N_IO-1:0]        io_out, io_oeb;
  logic [N_PROJ-1:0]      ena;
  logic                   irq;

  logic [N_IO-1:0] pat_out [N_PROJ];
  logic [N_IO-1:0] pat_oeb [N_PROJ];
  localparam logic [N_IO-1:0] PARK_OEB = '1;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q [$];
  string       name_q [$];

  always #5 clk = ~clk;

  chipalooza_project_sel #(
    .N_PROJ(N_PROJ), .N_IO(N_IO), .DEAD_CYCLES(16), .BASE_ADDR(BASE)
  ) dut (
    .wb_clk_i(clk), .wb_rstn_i(rstn),
    .wbs_stb_i(stb), .wbs_cyc_i(cyc), .wbs_we_i(we), .wbs_sel_i(sel),
    .wbs_adr_i(adr), .wbs_dat_i(wdat), .wbs_ack_o(ack), .wbs_dat_o(rdat),
    .proj_io_out(p_out), .proj_io_oeb(p_oeb),
    .io_out(io_out), .io_oeb(io_oeb), .proj_ena(ena), .irq(irq)
  );

  // Monitor: pops one expectation per acknowledged transfer.
  always @(negedge clk) begin
    if (ack === 1'b1) begin
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_ack: got dat=%08h, required no ack", rdat);
      end else begin
        logic [31:0] e;
        string n;
        e = exp_q.pop_front();
        n = name_q.pop_front();
        checks++;
        if (rdat !== e) begin
          errors++;
          $display("FAIL %s: got %08h, required %08h", n, rdat, e);
        end else begin
          $display("txn %s: dat=%08h", n, rdat);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  task automatic bus(input logic w, input logic [31:0] a, input logic [31:0] d,
                     input logic [3:0] s, input logic [31:0] exp, input string name);
    bit got;
    got = 1'b0;
    @(negedge clk);
    stb = 1'b1; cyc = 1'b1; we = w; adr = a; wdat = d; sel = s;
    exp_q.push_back(exp);
    name_q.push_back(name);
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (ack === 1'b1) begin
        got = 1'b1;
        break;
      end
    end
    stb = 1'b0; cyc = 1'b0; we = 1'b0;
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: got no ack, required ack within 8 cycles", name);
      void'(exp_q.pop_back());
      void'(name_q.pop_back());
    end
  endtask

  task automatic wr(input logic [3:0] r, input logic [31:0] d, input string name);
    bus(1'b1, BASE + {26'd0, r, 2'b00}, d, 4'hF, 32'd0, name);
  endtask

  task automatic rd(input logic [3:0] r, input logic [31:0] exp, input string name);
    bus(1'b0, BASE + {26'd0, r, 2'b00}, 32'd0, 4'hF, exp, name);
  endtask

  task automatic tick;
    @(posedge clk); #1;
  endtask

  task automatic chk_parked(input string name, input logic [N_PROJ-1:0] exp_ena);
    chk({name, "_ena"}, 64'(ena), 64'(exp_ena));
    chk({name, "_oeb"}, 64'(io_oeb), 64'(PARK_OEB));
    chk({name, "_out"}, 64'(io_out), 64'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish, required finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit seen;
    for (int k = 0; k < N_PROJ; k++) begin
      pat_out[k] = N_IO'(32'h02A5_5A5A ^ (32'(k) * 32'h0013_5791));
      pat_oeb[k] = N_IO'(32'h0155_AA00 + 32'(k) * 32'h0001_0203);
      p_out[k*N_IO +: N_IO] = pat_out[k];
      p_oeb[k*N_IO +: N_IO] = pat_oeb[k];
    end

    // Reset state
    repeat (3) tick();
    chk_parked("reset", '0);
    chk("reset_irq", 64'(irq), 64'd0);
    chk("reset_ack", 64'(ack), 64'd0);
    @(negedge clk) rstn = 1'b1;
    rd(4'd0, 32'h0000_00FF, "rd_sel_reset");
    rd(4'd1, 32'h0000_0010, "rd_dead_reset");
    rd(4'd2, 32'h0000_FF00, "rd_status_reset");
    rd(4'd3, 32'h0000_0000, "rd_irqen_reset");

    // Address miss never acks
    @(negedge clk);
    stb = 1'b1; cyc = 1'b1; we = 1'b0; adr = BASE + 32'h10; sel = 4'hF;
    seen = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (ack === 1'b1) seen = 1'b1;
    end
    stb = 1'b0; cyc = 1'b0;
    chk("miss_no_ack", 64'(seen), 64'd0);

    // SEL=3 with DEAD=4
    wr(4'd1, 32'd4, "wr_dead4");
    wr(4'd0, 32'd3, "wr_sel3");
    chk_parked("sel3_break", '0);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk_parked("sel3_dead", '0);
    end
    tick();
    chk_parked("sel3_make", 8'h08);
    tick();
    chk("sel3_stable_ena", 64'(ena), 64'h08);
    chk("sel3_out", 64'(io_out), 64'(pat_out[3]));
    chk("sel3_oeb", 64'(io_oeb), 64'(pat_oeb[3]));
    rd(4'd2, 32'h0000_0302, "rd_status_sel3");

    // SEL=5 with DEAD=0 and done interrupt
    wr(4'd2, 32'h6, "wr_clr_status");
    wr(4'd1, 32'd0, "wr_dead0");
    wr(4'd3, 32'd1, "wr_irqen1");
    wr(4'd0, 32'd5, "wr_sel5");
    chk_parked("sel5_break", '0);
    tick();
    chk_parked("sel5_dead", '0);
    tick();
    chk_parked("sel5_make", 8'h20);
    chk("sel5_make_irq", 64'(irq), 64'd0);
    tick();
    chk("sel5_out", 64'(io_out), 64'(pat_out[5]));
    chk("sel5_oeb", 64'(io_oeb), 64'(pat_oeb[5]));
    chk("sel5_done_irq", 64'(irq), 64'd0);
    tick();
    chk("sel5_irq_rise", 64'(irq), 64'd1);
    wr(4'd2, 32'h2, "wr_clr_done");
    chk("irq_clr_edge", 64'(irq), 64'd1);
    tick();
    chk("irq_dropped", 64'(irq), 64'd0);

    // SEL write while busy is rejected
    wr(4'd1, 32'd3, "wr_dead3");
    wr(4'd0, 32'd1, "wr_sel1");
    wr(4'd0, 32'd2, "wr_sel2_busy");
    repeat (4) tick();
    chk("sel1_ena", 64'(ena), 64'h02);
    chk("sel1_out", 64'(io_out), 64'(pat_out[1]));
    rd(4'd2, 32'h0000_0106, "rd_status_err");
    rd(4'd0, 32'h0000_0001, "rd_sel_kept");

    // Out-of-range index selects nothing
    wr(4'd2, 32'h6, "wr_clr_status2");
    wr(4'd0, 32'd9, "wr_sel9");
    repeat (6) tick();
    chk_parked("sel9_stable", '0);
    rd(4'd2, 32'h0000_FF02, "rd_status_none");
    rd(4'd0, 32'h0000_0009, "rd_sel9");

    // Reset in the middle of DEAD
    wr(4'd1, 32'd5, "wr_dead5");
    wr(4'd0, 32'd2, "wr_sel2");
    repeat (2) tick();
    chk_parked("pre_rst_dead", '0);
    @(negedge clk) rstn = 1'b0;
    tick();
    chk_parked("mid_rst", '0);
    chk("mid_rst_irq", 64'(irq), 64'd0);
    chk("mid_rst_ack", 64'(ack), 64'd0);
    chk("mid_rst_dat", 64'(rdat), 64'd0);
    @(negedge clk) rstn = 1'b1;
    rd(4'd0, 32'h0000_00FF, "rd_sel_rst2");
    rd(4'd1, 32'h0000_0010, "rd_dead_rst2");
    rd(4'd2, 32'h0000_FF00, "rd_status_rst2");
    rd(4'd3, 32'h0000_0000, "rd_irqen_rst2");

    // Byte-masked write and unused bits
    bus(1'b1, BASE + 32'h4, 32'h0000_FFFF, 4'b0010, 32'd0, "wr_dead_byte1");
    rd(4'd1, 32'h0000_FF10, "rd_dead_masked");
    wr(4'd3, 32'hFFFF_FFFF, "wr_irqen_all");
    rd(4'd3, 32'h0000_0003, "rd_irqen_masked");

    repeat (3) tick();
    chk("scoreboard_drain", 64'(exp_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
